// File: rtl/scan_mux_pkg.sv
// Shared types and default sizing for the scan_mux channel selector.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_STATIC = 2'd0,
        ST_DWELL  = 2'd1,
        ST_ADV    = 2'd2
    } state_e;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DWELL_W = 4;

    // A two-channel mux still needs one select bit, so clamp at 1.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_mux_next_ch.sv
// Finds the next enabled channel index above cur, wrapping to 0.
// Returns cur unchanged when no other channel is enabled.
module scan_mux_next_ch
    import scan_mux_pkg::*;
#(
    parameter int  NUM_CH = DEF_NUM_CH,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [SEL_W-1:0]  cur,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [SEL_W-1:0]  nxt,
    output logic              any_en
);

    logic             found;
    logic [SEL_W-1:0] cand;

    // Walk the channels in rotation order starting just above cur; first hit wins.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k < NUM_CH; k++) begin
            cand = SEL_W'((int'(cur) + k) % NUM_CH);
            if (!found && ch_en[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    assign any_en = |ch_en;

endmodule

// File: rtl/scan_mux.sv
// Registered channel selector with static selection and an auto-scan mode.
// Defining SCAN_MUX_LOCK_EN adds a lock input that freezes selection and FSM.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int  NUM_CH  = DEF_NUM_CH,
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  DWELL_W = DEF_DWELL_W,
    localparam int SEL_W   = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
`ifdef SCAN_MUX_LOCK_EN
    input  logic                     lock,
`endif
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         sel_out,
    output logic                     valid_out,
    output logic                     sel_chg
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               chg_q;
    logic               lock_w;
    logic               sel_in_ok;
    logic [SEL_W-1:0]   nxt_sel;
    logic               any_en;

`ifdef SCAN_MUX_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    assign sel_in_ok = ({{(32-SEL_W){1'b0}}, sel_in} < 32'(NUM_CH));

    scan_mux_next_ch #(
        .NUM_CH (NUM_CH)
    ) u_next_ch (
        .cur    (sel_q),
        .ch_en  (ch_en),
        .nxt    (nxt_sel),
        .any_en (any_en)
    );

    // Lock overrides everything; mode=0 wins over any scan progress and drops the count.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (!lock_w) begin
            if (!mode) begin
                state_d = ST_STATIC;
                cnt_d   = '0;
                if (sel_in_ok) begin
                    sel_d = sel_in;
                end
            end else begin
                unique case (state_q)
                    ST_STATIC: begin
                        state_d = ST_DWELL;
                        cnt_d   = dwell;
                    end
                    ST_DWELL: begin
                        if (cnt_q == '0) begin
                            state_d = ST_ADV;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    ST_ADV: begin
                        state_d = ST_DWELL;
                        cnt_d   = dwell;
                        if (any_en) begin
                            sel_d = nxt_sel;
                        end
                    end
                    default: begin
                        state_d = ST_STATIC;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        data_d  = '0;
        valid_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                valid_d = ch_en[i];
                data_d  = ch_en[i] ? data_in[i*DATA_W +: DATA_W] : '0;
            end
        end
    end

    // Reset clears chg_q directly so abandoning a scan never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STATIC;
            sel_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            chg_q   <= (sel_d != sel_q);
        end
    end

    assign data_out  = data_q;
    assign sel_out   = sel_q;
    assign valid_out = valid_q;
    assign sel_chg   = chg_q;

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter NUM_CH, default 4, number of input channels (legal 2..8).
REQ-002 Parameter DATA_W, default 8, bits per channel (legal 1..8).
REQ-003 Parameter DWELL_W, default 4, width of the dwell count.
REQ-004 Derived constant SEL_W = clog2(NUM_CH), minimum 1.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 mode  input  1  selection mode: 0 = static, 1 = auto-scan.
REQ-008 sel_in  input  SEL_W  channel index used in static mode.
REQ-009 ch_en  input  NUM_CH  per-channel enable mask; bit i enables channel i.
REQ-010 dwell  input  DWELL_W  cycles per channel in scan mode, minus one.
REQ-011 data_in  input  NUM_CH*DATA_W  packed channels; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-012 data_out  output  DATA_W  registered selected data.
REQ-013 sel_out  output  SEL_W  current registered selection, sel_q.
REQ-014 valid_out  output  1  registered; high when data_out comes from an enabled channel.
REQ-015 sel_chg  output  1  one-cycle pulse when sel_q changes value.

Function
REQ-016 States SHALL be ST_STATIC, ST_DWELL and ST_ADV. Every cycle, mode=0 SHALL force ST_STATIC and mode=1 SHALL leave ST_STATIC for ST_DWELL.
REQ-017 ST_STATIC: sel_q SHALL load sel_in when sel_in < NUM_CH; otherwise sel_q SHALL hold its value.
REQ-018 On entry to ST_DWELL, the dwell counter SHALL load dwell and then decrement once per cycle. At 0 the FSM SHALL go to ST_ADV.
REQ-019 ST_ADV SHALL last one cycle and SHALL set sel_q to the next enabled index above sel_q, wrapping at NUM_CH-1 to 0.
  - Only sel_q enabled: sel_q SHALL hold.
  - ch_en all zero: sel_q SHALL hold.
  - The FSM then SHALL re-enter ST_DWELL and reload the counter.
REQ-020 Each channel SHALL therefore be selected for dwell+2 cycles per scan step; dwell=0 gives 2 cycles.
REQ-021 data_out(t+1) SHALL equal channel sel_q(t) of data_in(t), a 1-cycle latency from sel_q.
REQ-022 valid_out(t+1) SHALL equal ch_en[sel_q(t)]. When valid_out is 0, data_out SHALL be 0.
REQ-023 sel_chg SHALL be high for exactly the cycle in which sel_out first shows a new value.
REQ-024 A mode change mid-dwell SHALL take effect on the next edge and discard the counter value. A return to scan SHALL restart from the current sel_q.
REQ-025 Changes to ch_en or dwell SHALL be sampled only at ST_ADV and at counter reload.

Reset
REQ-026 While rst=1, the FSM SHALL be ST_STATIC, sel_q 0, counter 0, data_out 0, valid_out 0 and sel_chg 0.
REQ-027 A reset mid-scan SHALL abandon the scan with no sel_chg pulse. Operation SHALL resume on the first edge after rst falls.

Configuration
REQ-028 With macro SCAN_MUX_LOCK_EN defined, the block SHALL add input lock (1 bit). While lock=1, sel_q and the FSM state SHALL freeze, and data_out/valid_out SHALL keep tracking the frozen sel_q.
REQ-029 Without SCAN_MUX_LOCK_EN, the lock port SHALL be absent and the behaviour SHALL be as if lock=0.

Structure
REQ-030 Package scan_mux_pkg SHALL hold the state enum and the default parameter constants.
REQ-031 Sub-module scan_mux_next_ch SHALL be the combinational next-enabled-index finder, with inputs cur and ch_en and outputs nxt and any_en.

Verification (NUM_CH=4, DATA_W=8, DWELL_W=4)
REQ-032 Reset: with rst high for 3 cycles and data_in=0x44332211 -> data_out=0x00, valid_out=0 and sel_out=0 throughout. One cycle after release, with sel_in=2 -> sel_out=2 and data_out=0x33 on the following edge.
REQ-033 Static out-of-range: with NUM_CH=3, sel_in=3 -> sel_out holds its previous value and sel_chg stays 0.
REQ-034 Scan wrap: mode=1, ch_en=4'b1011, dwell=1 -> sel_out sequence 0,1,3,0, each held 3 cycles, with one sel_chg pulse per change.
REQ-035 Masked channels: ch_en=4'b0000 in scan mode -> sel_out holds, valid_out=0, data_out=0x00. Setting ch_en=4'b0100 -> sel_out=2 after the next ST_ADV.
REQ-036 Mid-operation: mode drops to 0 mid-dwell with sel_in=1 -> sel_out=1 on the next edge. With SCAN_MUX_LOCK_EN, asserting lock for 5 cycles during a scan -> sel_out is constant and data_out tracks data_in changes on the locked channel.
